bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter; the inverse of the display-side binary-to-BCD stage. It accepts a packed multi-digit BCD value, such as tens/ones entered from keypad or switch logic. It returns the binary equivalent using the reverse double-dabble algorithm: shift right, then subtract 3 from any digit ≥ 8. One iteration executes per clock behind a start/busy/done handshake. Typical use: converting user-entered decimal setpoints back to binary for counters and comparators.

---
 rtl/bcd_to_bin_seq.sv | 130 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each SHIFT cycle performs one iteration: the whole work register
// {bcd, bin} is shifted right by one bit. Then every BCD digit field that
// reads 8 or more has 3 subtracted. After BIN_W iterations the binary field
// holds the result and the BCD field has drained to zero.
//
// Handshake: i_Start is sampled only in IDLE. It is a request, not a
// valid/ready pair. Accepting a legal request raises o_Busy on the same edge.
// o_Busy stays high until the completion edge. On that edge o_Busy falls and
// o_Done pulses for one cycle with o_Bin updated. An illegal request (any
// digit > 9) is answered on the accepting edge itself with o_Done and o_Err,
// and o_Busy never rises. Because the FSM is already in IDLE during the
// o_Done cycle, a request presented in that cycle is accepted.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        synchronous active-high reset, priority over i_Start
//   i_Start      conversion request (sampled only while idle)
//   i_Bcd        packed BCD input, ones digit in [3:0]
//   o_Bin        last converted binary value (registered)
//   o_Busy       conversion in progress (state == SHIFT)
//   o_Done       one-cycle completion pulse (valid result or error)
//   o_Err        last accepted request held an illegal digit
//   o_StateDbg   current FSM state (0 = IDLE, 1 = SHIFT) for observation
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Start,
   input  logic [4*DIGITS-1:0]   i_Bcd,
   output logic [BIN_W-1:0]      o_Bin,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Err,
   output logic                  o_StateDbg
);

   localparam int WORK_W = 4*DIGITS + BIN_W;
   // The counter only has to hold 0..BIN_W-1.
   localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W-1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state;
   logic [WORK_W-1:0]   work;
   logic [WORK_W-1:0]   shifted;
   logic [WORK_W-1:0]   corrected;
   logic [CNT_W-1:0]    cnt;
   logic                bcdBad;

   assign o_StateDbg = state;

   // Any digit above 9 makes the request illegal.
   always_comb begin
      bcdBad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (i_Bcd[4*d +: 4] > 4'd9) bcdBad = 1'b1;
      end
   end

   // One iteration: shift right, then correct all digit fields in parallel.
   // A digit reading 8+ after the shift was a 10+ weight before it, so
   // subtracting 3 restores a valid BCD digit (the reverse of add-3).
   always_comb begin
      shifted   = work >> 1;
      corrected = shifted;
      for (int d = 0; d < DIGITS; d++) begin
         if (shifted[BIN_W + 4*d +: 4] >= 4'd8) begin
            corrected[BIN_W + 4*d +: 4] = shifted[BIN_W + 4*d +: 4] - 4'd3;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state  <= IDLE;
         work   <= '0;
         cnt    <= '0;
         o_Bin  <= '0;
         o_Busy <= 1'b0;
         o_Done <= 1'b0;
         o_Err  <= 1'b0;
      end else begin
         o_Done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Start) begin
                  if (bcdBad) begin
                     // Rejected without ever becoming busy; o_Bin keeps
                     // the previous result.
                     o_Err  <= 1'b1;
                     o_Done <= 1'b1;
                  end else begin
                     work   <= {i_Bcd, {BIN_W{1'b0}}};
                     cnt    <= '0;
                     o_Err  <= 1'b0;
                     o_Busy <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work <= corrected;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  o_Bin  <= corrected[BIN_W-1:0];
                  o_Done <= 1'b1;
                  o_Busy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Bench for bcd_to_bin_seq with default parameters (2 digits, 7-bit result).
// Expected results come from decimal arithmetic on the BCD digits.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

   localparam int DIGITS = 2;
   localparam int BIN_W  = 7;
   localparam int MAX_WAIT = 20;

   logic                clk;
   logic                rst;
   logic                start;
   logic [4*DIGITS-1:0] bcd;
   logic [BIN_W-1:0]    bin;
   logic                busy;
   logic                done;
   logic                err;
   logic                stateDbg;

   int nChecks = 0;
   int nPass   = 0;
   int lastBin = 0;   // model of the most recent valid result

   typedef struct {
      logic [7:0] bcdIn;
      int         expBin;
      bit         expErr;
   } vec_t;

   vec_t vecs[6];

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Start    (start),
      .i_Bcd      (bcd),
      .o_Bin      (bin),
      .o_Busy     (busy),
      .o_Done     (done),
      .o_Err      (err),
      .o_StateDbg (stateDbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are driven and
   // outputs sampled here, well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: decimal value of the digits and legality.
   task automatic model(input logic [7:0] v, output int val, output bit bad);
      int d;
      val = 0;
      bad = 1'b0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         d = int'((v >> (4*i)) & 8'h0f);
         if (d > 9) bad = 1'b1;
         val = val*10 + d;
      end
   endtask

   // Present a one-cycle request and follow it to its o_Done.
   // edges: edges after the accepting edge at which o_Done was seen.
   // busyCnt: samples with o_Busy high from the accepting edge onward.
   task automatic runReq(input logic [7:0] v, output int edges,
                         output int busyCnt, output bit timedOut);
      bcd   = v;
      start = 1'b1;
      tick();
      start   = 1'b0;
      edges   = 0;
      busyCnt = busy ? 1 : 0;
      while (!done && edges < MAX_WAIT) begin
         tick();
         edges++;
         if (busy) busyCnt++;
      end
      timedOut = !done;
   endtask

   // Run one request against the model and check everything observable.
   task automatic checkReq(input string tag, input logic [7:0] v,
                           input int expBin, input bit expErr);
      int  edges, busyCnt;
      bit  tmo;
      runReq(v, edges, busyCnt, tmo);
      check({tag, " timeout"}, int'(tmo), 0);
      check({tag, " bin"}, int'(bin), expBin);
      check({tag, " err"}, int'(err), int'(expErr));
      check({tag, " latency"}, edges, expErr ? 0 : BIN_W);
      check({tag, " busy cycles"}, busyCnt, expErr ? 0 : BIN_W);
   endtask

   initial begin
      int  val, edges, busyCnt, doneCnt, doneEdge, doneBin;
      bit  bad, tmo;
      logic [7:0] r;

      vecs[0] = '{8'h63, 63, 1'b0};
      vecs[1] = '{8'h00,  0, 1'b0};
      vecs[2] = '{8'h99, 99, 1'b0};
      vecs[3] = '{8'h10, 10, 1'b0};
      vecs[4] = '{8'h5A, 10, 1'b1};   // illegal: result unchanged
      vecs[5] = '{8'h42, 42, 1'b0};

      // ---------------- reset ----------------
      rst = 1'b1; start = 1'b0; bcd = '0;
      repeat (3) tick();
      check("reset bin", int'(bin), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset err", int'(err), 0);
      check("reset state", int'(stateDbg), 0);
      rst = 1'b0;
      tick();

      // ---------------- table vectors ----------------
      for (int i = 0; i < 6; i++) begin
         checkReq($sformatf("vec%0d", i), vecs[i].bcdIn, vecs[i].expBin,
                  vecs[i].expErr);
         tick();
         check($sformatf("vec%0d done pulse width", i), int'(done), 0);
         check($sformatf("vec%0d err held", i), int'(err),
               int'(vecs[i].expErr));
      end
      lastBin = 42;

      // ---------------- start while busy ----------------
      bcd = 8'h27; start = 1'b1;
      tick();                         // edge 0
      start = 1'b0;
      tick(); tick();                 // edges 1, 2
      bcd = 8'h88; start = 1'b1;
      tick();                         // edge 3 sees the ignored request
      start = 1'b0;
      doneCnt = 0; doneEdge = -1; doneBin = -1;
      for (int k = 4; k < 4 + MAX_WAIT; k++) begin
         tick();
         if (done) begin
            doneCnt++;
            doneEdge = k;
            doneBin  = int'(bin);
         end
      end
      check("busy-start done count", doneCnt, 1);
      check("busy-start done edge", doneEdge, BIN_W);
      check("busy-start bin", doneBin, 27);
      lastBin = 27;

      // ---------------- back-to-back ----------------
      checkReq("b2b first", 8'h12, 12, 1'b0);
      // Still in the o_Done cycle of 12: next request is accepted at once.
      checkReq("b2b second", 8'h55, 55, 1'b0);
      lastBin = 55;
      tick();

      // ---------------- reset mid-conversion ----------------
      bcd = 8'h77; start = 1'b1;
      tick();                         // edge 0
      start = 1'b0;
      tick(); tick(); tick();         // edges 1..3
      rst = 1'b1;
      tick();                         // edge 4 resets
      rst = 1'b0;
      check("midrst bin", int'(bin), 0);
      check("midrst busy", int'(busy), 0);
      check("midrst done", int'(done), 0);
      check("midrst err", int'(err), 0);
      check("midrst state", int'(stateDbg), 0);
      doneCnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done) doneCnt++;
      end
      check("midrst no done", doneCnt, 0);
      lastBin = 0;

      // ---------------- reset has priority over start ----------------
      rst = 1'b1; start = 1'b1; bcd = 8'h33;
      tick();
      rst = 1'b0; start = 1'b0;
      check("rst+start busy", int'(busy), 0);
      tick();
      check("rst+start busy later", int'(busy), 0);
      check("rst+start done", int'(done), 0);

      // ---------------- random requests vs model ----------------
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         r = 8'($urandom_range(0, 255));
         model(r, val, bad);
         if (!bad) lastBin = val;
         checkReq($sformatf("rand %02h", r), r, lastBin, bad);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
